// File: rtl/uart_tx_controller.sv
// UART transmit controller: one start bit, N data bits LSB first, one stop bit,
// each bit held for 16 oversample ticks. Tx, done and all counters are registered.
module uart_tx_controller #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         rst,
  input  logic         tx_en,
  input  logic         tick,
  input  logic         tx_start,
  input  logic [N-1:0] tx_data,
  output logic         Tx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(N - 1);

  state_t       state_q, state_d;
  logic [3:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [N-1:0] shreg_q, shreg_d, shreg_shift;
  logic         tx_q, tx_d;
  logic         done_q, done_d;
  logic         abort, accept, bit_end, last_bit;

  // A soft reset or a disabled transmitter abandons the frame outright.
  assign abort       = rst | ~tx_en;
  assign accept      = (state_q == IDLE) & tx_start & ~abort;
  assign bit_end     = (state_q != IDLE) & tick & (tick_cnt_q == 4'd15);
  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign shreg_shift = shreg_q >> 1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = START;
        START:   if (bit_end) state_d = DATA;
        DATA:    if (bit_end && last_bit) state_d = STOP;
        STOP:    if (bit_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    if (abort) begin
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      tx_d       = 1'b1;
    end else if (state_q == IDLE) begin
      // tick is ignored while idle so every frame starts on a fresh bit period.
      tick_cnt_d = '0;
      tx_d       = 1'b1;
      if (accept) begin
        shreg_d   = tx_data;
        bit_cnt_d = '0;
        tx_d      = 1'b0;
      end
    end else begin
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
      if (bit_end) begin
        case (state_q)
          START: tx_d = shreg_q[0];
          DATA: begin
            shreg_d   = shreg_shift;
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = last_bit ? 1'b1 : shreg_shift[0];
          end
          STOP: begin
            tx_d   = 1'b1;
            done_d = 1'b1;
          end
          default: tx_d = 1'b1;
        endcase
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign Tx   = tx_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: frame shape, tick pacing, ignored
// requests while busy, soft/async reset abort, back-to-back frames, tx_en gating.
module tb_uart_tx_controller;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         arst_n, rst, tx_en, tick, tx_start;
  logic [N-1:0] tx_data;
  logic         Tx, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_controller #(.N(N)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rst      (rst),
    .tx_en    (tx_en),
    .tick     (tick),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .Tx       (Tx),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level for bit slot b of a frame: start, data LSB first, stop.
  function automatic logic exp_bit(input logic [N-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= N) return d[b-1];
    return 1'b1;
  endfunction

  // Sends one frame with a tick every p clocks and checks every cycle of it.
  // inj >= 0 pulses tx_start with all-ones data after sample inj (ignored request).
  // hold keeps tx_start high and swaps tx_data to next_data right after acceptance.
  task automatic run_frame(input string tag, input logic [N-1:0] data, input int p,
                           input int inj, input bit hold, input logic [N-1:0] next_data);
    int span, total, bad_tx, bad_busy, bad_done;
    span     = 16 * p;
    total    = (N + 2) * span;
    bad_tx   = 0;
    bad_busy = 0;
    bad_done = 0;
    tx_data  = data;
    tx_start = 1'b1;
    tick     = 1'b1;
    step();
    if (hold) tx_data = next_data;
    else tx_start = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (Tx !== exp_bit(data, k / span)) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if ((k % span) == span - 1) begin
        chk($sformatf("%s bit%0d cycles_wrong", tag, k / span), bad_tx, 0);
        bad_tx = 0;
      end
      tick = ((k + 1) % p) == 0;
      if (k == inj) begin
        tx_start = 1'b1;
        tx_data  = '1;
      end else if (k == inj + 1 && !hold) begin
        tx_start = 1'b0;
      end
      step();
    end
    chk({tag, " busy_low_cycles"}, bad_busy, 0);
    chk({tag, " early_done"}, bad_done, 0);
    chk({tag, " done_at_end"}, done, 1);
    chk({tag, " busy_at_end"}, busy, 0);
    chk({tag, " tx_at_end"}, Tx, 1);
    if (!hold) begin
      tick = 1'b1;
      step();
      chk({tag, " done_single"}, done, 0);
      chk({tag, " tx_idle"}, Tx, 1);
    end
  endtask

  initial begin
    int cnt_done, cnt_busy, cnt_low;
    arst_n   = 1'b0;
    rst      = 1'b0;
    tx_en    = 1'b1;
    tick     = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    #12;
    chk("reset tx", Tx, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    arst_n = 1'b1;

    // Idle with ticks present: line stays high, nothing starts.
    cnt_busy = 0;
    cnt_low  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0) cnt_busy++;
      if (Tx !== 1'b1) cnt_low++;
    end
    chk("idle busy", cnt_busy, 0);
    chk("idle tx", cnt_low, 0);

    // 1: 0xA5 at one tick per clock.
    run_frame("t1", 8'hA5, 1, -5, 1'b0, 8'h00);

    // 2: 0x00 at one tick every 4 clocks.
    run_frame("t2", 8'h00, 4, -5, 1'b0, 8'h00);

    // 3: request with 0xFF during DATA is ignored.
    run_frame("t3", 8'h5A, 1, 16 * 4 + 3, 1'b0, 8'h00);

    // 4: soft reset after 40 ticks abandons the frame.
    tx_data  = 8'h35;
    tx_start = 1'b1;
    tick     = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("t4 busy_before_rst", busy, 1);
    chk("t4 tx_before_rst", Tx, 0);
    rst = 1'b1;
    step();
    chk("t4 tx_after_rst", Tx, 1);
    chk("t4 busy_after_rst", busy, 0);
    chk("t4 done_after_rst", done, 0);
    tx_start = 1'b1;
    step();
    chk("t4 rst_beats_start", busy, 0);
    tx_start = 1'b0;
    rst      = 1'b0;
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done !== 1'b0) cnt_done++;
      if (busy !== 1'b0) cnt_busy++;
    end
    chk("t4 no_done", cnt_done, 0);
    chk("t4 stays_idle", cnt_busy, 0);
    run_frame("t4b", 8'h96, 1, -5, 1'b0, 8'h00);

    // 5: tx_start held high, back-to-back frames.
    run_frame("t5a", 8'h3C, 1, -5, 1'b1, 8'hC3);
    run_frame("t5b", 8'hC3, 1, -5, 1'b0, 8'h00);

    // 6: asynchronous reset inside the stop bit.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick     = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 150; i++) step();
    chk("t6 busy_in_stop", busy, 1);
    #3;
    arst_n = 1'b0;
    #1;
    chk("t6 arst tx", Tx, 1);
    chk("t6 arst busy", busy, 0);
    chk("t6 arst done", done, 0);
    #2;
    arst_n = 1'b1;
    step();
    chk("t6 idle_after_arst", busy, 0);

    // tx_en low blocks a start request.
    tx_en    = 1'b0;
    tx_start = 1'b1;
    cnt_busy = 0;
    cnt_low  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0) cnt_busy++;
      if (Tx !== 1'b1) cnt_low++;
    end
    chk("t6 txen_busy", cnt_busy, 0);
    chk("t6 txen_tx", cnt_low, 0);
    tx_start = 1'b0;
    tx_en    = 1'b1;
    step();
    run_frame("t6b", 8'h0F, 2, -5, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
